// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and frame-state encoding for the PS/2 key receiver
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_REL    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_e;

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-flop synchronizer plus FILT_LEN-sample glitch filter for one PS/2 line
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic line_in,
    output logic line_out
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The output only flips after FILT_LEN consecutive samples disagree with it.
    always_comb begin
        sync1_d = line_in;
        sync2_d = sync1_q;
        out_d   = out_q;
        cnt_d   = '0;
        if (sync2_q != out_q) begin
            if (cnt_q == CNT_LAST) begin
                out_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            out_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign line_out = out_q;

endmodule

// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard frame receiver and scan-code decoder producing the ps2_key event word
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILT_LEN = 8,
    parameter int TIMEOUT  = 100000,
    parameter int TO_W     = 17
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [10:0] ps2_key,
    output logic        rx_err,
    output logic        rx_byte_v
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic clk_f, dat_f, fall;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .line_in  (ps2_clk),
        .line_out (clk_f)
    );

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .line_in  (ps2_dat),
        .line_out (dat_f)
    );

    frame_state_e    state_q, state_d;
    logic            clk_prev_q, clk_prev_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            byte_v_q, byte_v_d;
    logic [7:0]      byte_q, byte_d;
    logic            err_q, err_d;
    logic [10:0]     key_q, key_d;
    logic            ext_q, ext_d;
    logic            rel_q, rel_d;
    logic [2:0]      skip_q, skip_d;

    assign clk_prev_d = clk_f;
    assign fall       = clk_prev_q & ~clk_f;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        to_cnt_d  = to_cnt_q;
        byte_d    = byte_q;
        byte_v_d  = 1'b0;
        err_d     = 1'b0;
        // A fall in the same cycle as the timeout takes precedence.
        if (fall) begin
            to_cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!dat_f) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_f, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dat_f;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (dat_f && (^{shift_q, par_q})) begin
                        byte_v_d = 1'b1;
                        byte_d   = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            to_cnt_d = '0;
            state_d  = IDLE;
            err_d    = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_comb begin
        key_d  = key_q;
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        if (err_q) begin
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = '0;
        end else if (byte_v_q) begin
            if (skip_q != '0) begin
                skip_d = skip_q - 1'b1;
            end else if (byte_q == PS2_PAUSE) begin
                skip_d = PAUSE_SKIP;
            end else if (byte_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (byte_q == PS2_REL) begin
                rel_d = 1'b1;
            end else begin
                key_d = {~key_q[10], ~rel_q, ext_q, byte_q};
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            byte_v_q   <= 1'b0;
            byte_q     <= '0;
            err_q      <= 1'b0;
            key_q      <= '0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            skip_q     <= '0;
        end else begin
            state_q    <= state_d;
            clk_prev_q <= clk_prev_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            byte_v_q   <= byte_v_d;
            byte_q     <= byte_d;
            err_q      <= err_d;
            key_q      <= key_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            skip_q     <= skip_d;
        end
    end

    assign ps2_key   = key_q;
    assign rx_err    = err_q;
    assign rx_byte_v = byte_v_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb/tb_ps2_key_rx.sv - self-checking bench for ps2_key_rx against a byte-level reference model
module tb_ps2_key_rx;

    localparam int TIMEOUT = 2000;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [10:0] ps2_key;
    logic        rx_err;
    logic        rx_byte_v;

    always #5 clk_sys = ~clk_sys;

    ps2_key_rx #(
        .FILT_LEN (8),
        .TIMEOUT  (TIMEOUT),
        .TO_W     (17)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .ps2_key   (ps2_key),
        .rx_err    (rx_err),
        .rx_byte_v (rx_byte_v)
    );

    int n_vec = 0;
    int n_mis = 0;

    // High-cycle counts: a single-cycle pulse adds exactly one.
    int mon_err = 0;
    int mon_bv  = 0;
    always @(negedge clk_sys) begin
        if (!reset) begin
            if (rx_err)    mon_err++;
            if (rx_byte_v) mon_bv++;
        end
    end

    logic [10:0] m_key  = '0;
    bit          m_ext  = 0;
    bit          m_rel  = 0;
    int          m_skip = 0;
    int          exp_err = 0;
    int          exp_bv  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        if (obs !== want) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic model_err();
        exp_err++;
        m_ext  = 0;
        m_rel  = 0;
        m_skip = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit bad);
        if (bad) begin
            model_err();
        end else begin
            exp_bv++;
            if (m_skip > 0)        m_skip--;
            else if (b == 8'hE1)   m_skip = 7;
            else if (b == 8'hE0)   m_ext = 1;
            else if (b == 8'hF0)   m_rel = 1;
            else begin
                m_key = {~m_key[10], ~m_rel, m_ext, b};
                m_ext = 0;
                m_rel = 0;
            end
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad, input int nbits, input int hp);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            cyc(hp);
            ps2_clk = 1'b0;
            cyc(hp);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".key"}, 32'(ps2_key), 32'(m_key));
        chk({tag, ".err"}, 32'(mon_err), 32'(exp_err));
        chk({tag, ".bv"},  32'(mon_bv),  32'(exp_bv));
    endtask

    task automatic frame(input logic [7:0] b, input bit bad, input string tag);
        int hp;
        hp = int'($urandom_range(40, 80));
        send_bits(b, bad, 11, hp);
        cyc(hp);
        model_byte(b, bad);
        check_state(tag);
    endtask

    logic [10:0] saved_key;
    logic [7:0]  rb;
    int          r;

    initial begin
        cyc(5);
        reset = 1'b0;
        cyc(2);
        chk("rst.key", 32'(ps2_key), 32'h0);
        chk("rst.err", 32'(rx_err), 32'h0);
        chk("rst.bv",  32'(rx_byte_v), 32'h0);

        frame(8'h29, 0, "t1");
        chk("t1.val", 32'(ps2_key), 32'h629);

        frame(8'hF0, 0, "t2a");
        frame(8'h29, 0, "t2b");
        chk("t2.val", 32'(ps2_key), 32'h029);

        frame(8'hE0, 0, "t3a");
        frame(8'h75, 0, "t3b");
        chk("t3.ext", 32'(ps2_key[9:0]), 32'h375);
        frame(8'hE0, 0, "t3c");
        frame(8'hF0, 0, "t3d");
        frame(8'h75, 0, "t3e");
        chk("t3.extrel", 32'(ps2_key[9:0]), 32'h175);

        saved_key = ps2_key;
        frame(8'h1C, 1, "t4bad");
        chk("t4.hold", 32'(ps2_key), 32'(saved_key));
        frame(8'h1C, 0, "t4good");
        chk("t4.val", 32'(ps2_key[9:0]), 32'h21C);

        send_bits(8'h5A, 0, 5, 60);
        cyc(TIMEOUT + 10);
        model_err();
        check_state("to");
        frame(8'h4B, 0, "to.next");

        for (int g = 0; g < 4; g++) begin
            ps2_clk = 1'b0;
            cyc(3);
            ps2_clk = 1'b1;
            cyc(25);
        end
        check_state("glitch");

        send_bits(8'h33, 0, 4, 60);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        m_key  = '0;
        m_ext  = 0;
        m_rel  = 0;
        m_skip = 0;
        cyc(20);
        check_state("midrst");
        frame(8'h16, 0, "post");
        chk("post.val", 32'(ps2_key), 32'h616);

        for (int k = 0; k < 14; k++) begin
            r  = int'($urandom_range(0, 11));
            rb = 8'($urandom);
            case (r)
                0, 1:    frame(8'hE0, 0, "rnd");
                2, 3:    frame(8'hF0, 0, "rnd");
                4:       frame(8'hE1, 0, "rnd");
                5:       frame(rb, 1, "rnd");
                default: frame(rb, 0, "rnd");
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
